// File: rtl/cs_ctrl.sv
// cs_ctrl: clip/split stack controller.
// Accepts one upstream triangle at a time, pushes it onto an external stack, then loops popping a
// triangle, classifying it (accept / reject / split), emitting accepted triangles downstream and
// pushing both halves of split triangles back onto the stack until the stack drains.
//
// Ports:
//   clk, n_rst            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready only in IDLE)
//   out_valid / out_ready downstream handshake for the stack output triangle
//   stack_push/stack_pop  stack strobes; push_sel picks upstream (00), half A (01), half B (10)
//   cls_accept/cls_reject classifier result for the popped triangle, sampled in TEST
//   split_start/split_done splitter handshake
//   depth                 stack occupancy
//   busy                  state is not IDLE
//   overflow              sticky: a triangle was dropped for lack of stack space
//
// Optional: define CS_CTRL_STATS_EN to add saturating 16-bit acc_cnt/rej_cnt/drop_cnt outputs.
module cs_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          stack_push,
  output logic          stack_pop,
  output logic [1:0]    push_sel,
  input  logic          cls_accept,
  input  logic          cls_reject,
  output logic          split_start,
  input  logic          split_done,
  output logic [DW-1:0] depth,
  output logic          busy,
  output logic          overflow
`ifdef CS_CTRL_STATS_EN
  ,
  output logic [15:0]   acc_cnt,
  output logic [15:0]   rej_cnt,
  output logic [15:0]   drop_cnt
`endif
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPop   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StTest  = 3'd3;
  localparam logic [2:0] StSplit = 3'd4;
  localparam logic [2:0] StPushA = 3'd5;
  localparam logic [2:0] StPushB = 3'd6;
  localparam logic [2:0] StEmit  = 3'd7;

  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);
  localparam logic [DW-1:0] SplitLim = DW'(DEPTH - 2);
  localparam logic [DW-1:0] DepthOne = DW'(1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_d;
  logic [DW-1:0] r_depth;
  logic [DW-1:0] w_depth_d;
  logic          r_overflow;
  logic          r_split_start;

  logic w_in_hs;
  logic w_emit_hs;
  logic w_test_rej;
  logic w_test_acc;
  logic w_test_split;
  logic w_test_drop;
  logic w_depth_nz;

  assign w_in_hs      = (r_state == StIdle) && in_valid;
  assign w_emit_hs    = (r_state == StEmit) && out_ready;
  assign w_test_rej   = (r_state == StTest) && cls_reject;
  assign w_test_acc   = (r_state == StTest) && cls_accept && !cls_reject;
  // Neither flag: split if two more entries fit, otherwise drop.
  assign w_test_split = (r_state == StTest) && !cls_accept && !cls_reject && (r_depth <= SplitLim);
  assign w_test_drop  = (r_state == StTest) && !cls_accept && !cls_reject && (r_depth > SplitLim);
  assign w_depth_nz   = (r_depth != '0);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = StPop;
      StPop:   w_state_d = StWait;
      StWait:  w_state_d = StTest;
      StTest: begin
        if (w_test_rej || w_test_drop) w_state_d = w_depth_nz ? StPop : StIdle;
        else if (w_test_acc)           w_state_d = StEmit;
        else                           w_state_d = StSplit;
      end
      // split_done may still be held from the previous split while our start pulse is out.
      StSplit: if (split_done && !r_split_start) w_state_d = StPushA;
      StPushA: w_state_d = StPushB;
      StPushB: w_state_d = StPop;
      StEmit:  if (out_ready) w_state_d = w_depth_nz ? StPop : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_depth_d = r_depth;
    if (stack_push && (r_depth != DepthMax)) w_depth_d = r_depth + DepthOne;
    else if (stack_pop && w_depth_nz)        w_depth_d = r_depth - DepthOne;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= StIdle;
      r_depth       <= '0;
      r_overflow    <= 1'b0;
      r_split_start <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_depth       <= w_depth_d;
      r_split_start <= w_test_split;
      if (w_test_drop) r_overflow <= 1'b1;
    end
  end

  // The upstream push is the in_valid/in_ready handshake itself; all else is state-decoded.
  assign in_ready    = (r_state == StIdle);
  assign stack_push  = w_in_hs || (r_state == StPushA) || (r_state == StPushB);
  assign stack_pop   = (r_state == StPop);
  assign push_sel    = (r_state == StPushA) ? 2'b01 : (r_state == StPushB) ? 2'b10 : 2'b00;
  assign out_valid   = (r_state == StEmit);
  assign busy        = (r_state != StIdle);
  assign split_start = r_split_start;
  assign depth       = r_depth;
  assign overflow    = r_overflow;

`ifdef CS_CTRL_STATS_EN
  logic [15:0] r_acc_cnt;
  logic [15:0] r_rej_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc_cnt  <= '0;
      r_rej_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_emit_hs && (r_acc_cnt != 16'hFFFF))    r_acc_cnt  <= r_acc_cnt + 16'd1;
      if (w_test_rej && (r_rej_cnt != 16'hFFFF))   r_rej_cnt  <= r_rej_cnt + 16'd1;
      if (w_test_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign acc_cnt  = r_acc_cnt;
  assign rej_cnt  = r_rej_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_emit_hs;
  assign w_unused_emit_hs = w_emit_hs;
`endif

endmodule
